nsdp_stream_checker: RTL and testbench
======================================

Name: nsdp_stream_checker

Overview:
- Per-channel NSDP packet checker; one instance per Ethernet channel (ch0, ch1).
- Sinks the 512-bit AXI-Stream of received NSDP packets and verifies target address, frame counter and frame-data pattern.
- Latches the first error with its offending beat and counts packets.
- Outputs feed the channel's status/error/expected/packet-count inputs of the AXI register reporter.

Parameters:
- PKT_BEATS, 64, data beats per packet (64 B each; default 4 KB payload).
- TADDR_BASE, 64'h0, first expected target address.
- TADDR_SIZE, 64'h1_0000_0000, target ring size in bytes; expected address wraps to TADDR_BASE.
- FDATA_SEED, 32'h0, first expected 32-bit frame-data word.
- ACTIVE_TIMEOUT, 250_000_000, idle cycles before eth_active drops.

Ports:
- clk  in  1  single clock
- resetn  in  1  reset; asynchronous and active-low
- clear  in  1  one-cycle pulse: restart checking, clear error state and counters
- AXIS_RX_TDATA  in  512  packet beat
- AXIS_RX_TVALID  in  1  beat valid
- AXIS_RX_TLAST  in  1  last beat of packet
- AXIS_RX_TREADY  out  1  always 1 out of reset
- eth_active  out  1  beat seen within last ACTIVE_TIMEOUT cycles
- status  out  1  1 = error latched
- error  out  15  latched error bits
- error_data  out  512  TDATA of first failing beat
- expected_fdata  out  32  expected word 0 of next/failing data beat
- expected_taddr  out  64  expected header target address
- expected_fc  out  32  expected header frame counter
- packets_rcvd  out  64  count of TLAST beats accepted

Behaviour:
- Reset values:
  - TREADY=0 during reset, 1 afterwards.
  - status=0, error=0, error_data=0, packets_rcvd=0, eth_active=0.
  - expected_taddr=TADDR_BASE, expected_fc=0, expected_fdata=FDATA_SEED.
  - State S_HDR.
- Beat accepted when TVALID & TREADY.
- Packet format:
  - Header beat: [63:0] taddr, [95:64] frame counter, [511:96] ignored.
  - Then PKT_BEATS data beats. Data word i is TDATA[32i+:32]; expected value is expected_fdata+i (mod 2^32).
- States:
  - S_HDR:
    - On beat, compare taddr → bit0, fc → bit1. TLAST on header → bit3.
    - No error: go to S_DATA, beat counter=0.
  - S_DATA:
    - On beat, any of 16 words mismatched → bit2.
    - TLAST with counter<PKT_BEATS-1 → bit3 (short).
    - counter==PKT_BEATS-1 without TLAST → bit4 (long).
    - No error: expected_fdata += 16; counter++.
    - On final good beat:
      - expected_fc += 1.
      - expected_taddr += PKT_BEATS*64; if result ≥ TADDR_BASE+TADDR_SIZE, expected_taddr=TADDR_BASE.
      - Go to S_HDR.
  - S_ERR:
    - Entered on any error.
    - Error bits: OR of all bits raised by that beat.
    - error_data = that beat; status=1.
    - expected_* frozen at values used for the failing comparison.
    - No further checking until clear.
  - S_SYNC:
    - Entered by clear while mid-packet (S_DATA, or S_ERR).
    - Discard beats until TLAST, then S_HDR.
- Latency: error/status/error_data/expected_* update on the clock edge after the failing beat is accepted (registered, 1 cycle).
- packets_rcvd:
  - +1 on every accepted TLAST beat in any state, including S_ERR and S_SYNC.
  - Wraps at 2^64.
- error bits [14:5] always 0.
- clear:
  - Zeroes status, error, error_data, packets_rcvd.
  - Restores expected_* to reset values.
  - Next state: S_HDR if in S_HDR; otherwise S_SYNC.
  - Clear concurrent with a beat:
    - Clear wins; the beat is not checked.
    - If that beat has TLAST, next state is S_HDR and packets_rcvd = 0 (not 1).
- eth_active:
  - Idle counter reloads to ACTIVE_TIMEOUT on each accepted beat; eth_active=1.
  - Decrements otherwise; eth_active=0 when it reaches 0.
  - Saturates at 0; clear has no effect on it.
- Reset mid-packet: immediate return to reset values; first beat after reset is treated as a header.

Optional Feature:
- Macro NSDP_ERR_INJECT_EN.
- When defined:
  - Adds input inject_err (1 bit).
  - A pulse arms a flag; the next S_DATA beat compares word 0 against ~(expected_fdata), forcing bit2, then the flag clears.
  - Flag is cleared by reset/clear.
- When undefined: no port, no flag; behaviour exactly as above.

Decomposition:
- Shared package nsdp_pkg holds:
  - Error bit indices ERR_TADDR=0, ERR_FC=1, ERR_FDATA=2, ERR_SHORT=3, ERR_LONG=4.
  - Header field offsets.
  - State encodings S_HDR/S_DATA/S_ERR/S_SYNC.
  - Beat width 512.
- One sub-module nsdp_fdata_compare: combinational 16-lane comparator, inputs TDATA and expected_fdata, output 16-bit mismatch vector.

Test Plan:
- 3 good packets, PKT_BEATS=4, defaults → error=0, status=0, packets_rcvd=3, expected_fc=3, expected_taddr=0x300, expected_fdata=0xC0.
- Packet 2 data beat 1 word 5 = 0xDEAD → error=0x0004, status=1, error_data=that beat, expected_fdata=0x50; later packets still counted.
- TADDR_SIZE=0x200, 3 good packets → third header expects taddr=0x000 (wrap); no error.
- TLAST on data beat 1 of 4 → error=0x0008; 4 data beats without TLAST → error=0x0010.
- Clear asserted mid-packet after an error → status=0, packets_rcvd=0; remaining beats discarded; next header checked against taddr=0, fc=0.
- No beats for ACTIVE_TIMEOUT (set 10) cycles after one beat → eth_active 1 for 10 cycles, then 0.

Source files
------------

// File: rtl/nsdp_pkg.sv
// Shared constants and types for the NSDP stream checker.
package nsdp_pkg;

    localparam int BEAT_W = 512;
    localparam int WORD_W = 32;
    localparam int LANES  = BEAT_W / WORD_W;
    localparam int ERR_W  = 15;

    localparam int ERR_TADDR = 0;
    localparam int ERR_FC    = 1;
    localparam int ERR_FDATA = 2;
    localparam int ERR_SHORT = 3;
    localparam int ERR_LONG  = 4;

    localparam int HDR_TADDR_LSB = 0;
    localparam int HDR_TADDR_W   = 64;
    localparam int HDR_FC_LSB    = 64;
    localparam int HDR_FC_W      = 32;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_ERR  = 2'd2,
        S_SYNC = 2'd3
    } state_e;

endpackage

// File: rtl/nsdp_stream_checker_fdata_compare.sv
// Sixteen-lane frame-data comparator: lane i expects expected_fdata_i + i.
module nsdp_fdata_compare
    import nsdp_pkg::*;
(
    input  logic [BEAT_W-1:0] tdata_i,
    input  logic [WORD_W-1:0] expected_fdata_i,
    output logic [LANES-1:0]  mismatch_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign mismatch_o[i] =
            tdata_i[i*WORD_W +: WORD_W] != (expected_fdata_i + WORD_W'(i));
    end

endmodule

// File: rtl/nsdp_stream_checker.sv
// Per-channel NSDP packet checker; NSDP_ERR_INJECT_EN adds inject_err.
module nsdp_stream_checker
    import nsdp_pkg::*;
#(
    parameter int unsigned PKT_BEATS      = 64,
    parameter logic [63:0] TADDR_BASE     = 64'h0,
    parameter logic [63:0] TADDR_SIZE     = 64'h1_0000_0000,
    parameter logic [31:0] FDATA_SEED     = 32'h0,
    parameter int unsigned ACTIVE_TIMEOUT = 250_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
`ifdef NSDP_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    input  logic [BEAT_W-1:0] AXIS_RX_TDATA,
    input  logic              AXIS_RX_TVALID,
    input  logic              AXIS_RX_TLAST,
    output logic              AXIS_RX_TREADY,
    output logic              eth_active,
    output logic              status,
    output logic [ERR_W-1:0]  error,
    output logic [BEAT_W-1:0] error_data,
    output logic [31:0]       expected_fdata,
    output logic [63:0]       expected_taddr,
    output logic [31:0]       expected_fc,
    output logic [63:0]       packets_rcvd
);

    localparam int BCW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int ACW = (ACTIVE_TIMEOUT > 0) ? $clog2(ACTIVE_TIMEOUT + 1) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(PKT_BEATS - 1);
    localparam logic [ACW-1:0] ACT_LOAD  = ACW'(ACTIVE_TIMEOUT);
    localparam logic [63:0] PKT_BYTES = 64'(PKT_BEATS) * 64'd64;
    localparam logic [63:0] TADDR_END = TADDR_BASE + TADDR_SIZE;

    state_e             state_q;
    logic [BCW-1:0]     bcnt_q;
    logic               tready_q;
    logic [ACW-1:0]     act_cnt_q;
    logic               act_q;
    logic               status_q;
    logic [ERR_W-1:0]   error_q;
    logic [BEAT_W-1:0]  edata_q;
    logic [31:0]        exp_fdata_q;
    logic [63:0]        exp_taddr_q;
    logic [31:0]        exp_fc_q;
    logic [63:0]        pkts_q;

    logic               beat;
    logic [LANES-1:0]   lane_mis;
    logic               fdata_bad;
    logic [ERR_W-1:0]   hdr_err;
    logic [ERR_W-1:0]   data_err;
    logic [63:0]        taddr_sum;
    logic [63:0]        taddr_d;

    assign beat = AXIS_RX_TVALID & tready_q;

    nsdp_fdata_compare u_cmp (
        .tdata_i          (AXIS_RX_TDATA),
        .expected_fdata_i (exp_fdata_q),
        .mismatch_o       (lane_mis)
    );

`ifdef NSDP_ERR_INJECT_EN
    logic inj_q;

    // An armed flag turns lane 0 into a comparison against the inverted word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inj_q <= 1'b0;
        end else if (clear) begin
            inj_q <= 1'b0;
        end else if (beat && state_q == S_DATA) begin
            inj_q <= inject_err;
        end else if (inject_err) begin
            inj_q <= 1'b1;
        end
    end

    assign fdata_bad = (|lane_mis[LANES-1:1]) |
        (inj_q ? (AXIS_RX_TDATA[WORD_W-1:0] != ~exp_fdata_q)
               : lane_mis[0]);
`else
    assign fdata_bad = |lane_mis;
`endif

    always_comb begin
        hdr_err  = '0;
        data_err = '0;
        hdr_err[ERR_TADDR] =
            AXIS_RX_TDATA[HDR_TADDR_LSB +: HDR_TADDR_W] != exp_taddr_q;
        hdr_err[ERR_FC] =
            AXIS_RX_TDATA[HDR_FC_LSB +: HDR_FC_W] != exp_fc_q;
        hdr_err[ERR_SHORT]  = AXIS_RX_TLAST;
        data_err[ERR_FDATA] = fdata_bad;
        data_err[ERR_SHORT] = AXIS_RX_TLAST && (bcnt_q < LAST_BEAT);
        data_err[ERR_LONG]  = !AXIS_RX_TLAST && (bcnt_q == LAST_BEAT);
    end

    assign taddr_sum = exp_taddr_q + PKT_BYTES;
    assign taddr_d   = (taddr_sum >= TADDR_END) ? TADDR_BASE : taddr_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tready_q  <= 1'b0;
            act_cnt_q <= '0;
            act_q     <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (beat) begin
                act_cnt_q <= ACT_LOAD;
                act_q     <= 1'b1;
            end else if (act_cnt_q != '0) begin
                act_cnt_q <= act_cnt_q - ACW'(1);
                act_q     <= (act_cnt_q != ACW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_HDR;
            bcnt_q      <= '0;
            status_q    <= 1'b0;
            error_q     <= '0;
            edata_q     <= '0;
            exp_fdata_q <= FDATA_SEED;
            exp_taddr_q <= TADDR_BASE;
            exp_fc_q    <= '0;
            pkts_q      <= '0;
        end else if (clear) begin
            // A beat arriving with clear is dropped unchecked.
            state_q     <= (state_q == S_HDR || (beat && AXIS_RX_TLAST))
                         ? S_HDR : S_SYNC;
            bcnt_q      <= '0;
            status_q    <= 1'b0;
            error_q     <= '0;
            edata_q     <= '0;
            exp_fdata_q <= FDATA_SEED;
            exp_taddr_q <= TADDR_BASE;
            exp_fc_q    <= '0;
            pkts_q      <= '0;
        end else if (beat) begin
            if (AXIS_RX_TLAST) begin
                pkts_q <= pkts_q + 64'd1;
            end
            unique case (state_q)
                S_HDR: begin
                    if (|hdr_err) begin
                        state_q  <= S_ERR;
                        status_q <= 1'b1;
                        error_q  <= hdr_err;
                        edata_q  <= AXIS_RX_TDATA;
                    end else begin
                        state_q <= S_DATA;
                        bcnt_q  <= '0;
                    end
                end
                S_DATA: begin
                    if (|data_err) begin
                        state_q  <= S_ERR;
                        status_q <= 1'b1;
                        error_q  <= data_err;
                        edata_q  <= AXIS_RX_TDATA;
                    end else begin
                        exp_fdata_q <= exp_fdata_q + 32'(LANES);
                        bcnt_q      <= bcnt_q + BCW'(1);
                        if (bcnt_q == LAST_BEAT) begin
                            exp_fc_q    <= exp_fc_q + 32'd1;
                            exp_taddr_q <= taddr_d;
                            state_q     <= S_HDR;
                        end
                    end
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                S_SYNC: begin
                    if (AXIS_RX_TLAST) begin
                        state_q <= S_HDR;
                    end
                end
            endcase
        end
    end

    assign AXIS_RX_TREADY = tready_q;
    assign eth_active     = act_q;
    assign status         = status_q;
    assign error          = error_q;
    assign error_data     = edata_q;
    assign expected_fdata = exp_fdata_q;
    assign expected_taddr = exp_taddr_q;
    assign expected_fc    = exp_fc_q;
    assign packets_rcvd   = pkts_q;

endmodule

// File: tb/tb_nsdp_stream_checker.sv
// Scoreboard bench for nsdp_stream_checker (PKT_BEATS=4, 0x400 ring).
module tb_nsdp_stream_checker;

    localparam int          PB    = 4;
    localparam logic [63:0] TBASE = 64'h0;
    localparam logic [63:0] TSIZE = 64'h400;
    localparam logic [31:0] FSEED = 32'h0;
    localparam int          TOUT  = 10;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         clear = 1'b0;
    logic         inj = 1'b0;
    logic [511:0] tdata = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         active;
    logic         status;
    logic [14:0]  error;
    logic [511:0] edata;
    logic [31:0]  exp_fdata;
    logic [63:0]  exp_taddr;
    logic [31:0]  exp_fc;
    logic [63:0]  pkts;

    always #5 clk = ~clk;

    nsdp_stream_checker #(
        .PKT_BEATS      (PB),
        .TADDR_BASE     (TBASE),
        .TADDR_SIZE     (TSIZE),
        .FDATA_SEED     (FSEED),
        .ACTIVE_TIMEOUT (TOUT)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .clear          (clear),
`ifdef NSDP_ERR_INJECT_EN
        .inject_err     (inj),
`endif
        .AXIS_RX_TDATA  (tdata),
        .AXIS_RX_TVALID (tvalid),
        .AXIS_RX_TLAST  (tlast),
        .AXIS_RX_TREADY (tready),
        .eth_active     (active),
        .status         (status),
        .error          (error),
        .error_data     (edata),
        .expected_fdata (exp_fdata),
        .expected_taddr (exp_taddr),
        .expected_fc    (exp_fc),
        .packets_rcvd   (pkts)
    );

    typedef struct {
        logic         st;
        logic [14:0]  err;
        logic [511:0] ed;
        logic [63:0]  pk;
        logic [63:0]  ta;
        logic [31:0]  fc;
        logic [31:0]  fd;
    } snap_t;

    snap_t sb[$];
    snap_t s;
    int n_chk = 0;
    int n_pass = 0;

    // Reference model state: 0 hdr, 1 data, 2 err, 3 sync.
    int           m_st;
    int           m_bc;
    logic         m_status;
    logic [14:0]  m_err;
    logic [511:0] m_ed;
    logic [63:0]  m_pk;
    logic [63:0]  m_ta;
    logic [31:0]  m_fc;
    logic [31:0]  m_fd;

    task automatic check(input string tag, input logic [511:0] act,
                         input logic [511:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_st = 0; m_bc = 0; m_status = 0; m_err = '0; m_ed = '0;
        m_pk = '0; m_ta = TBASE; m_fc = '0; m_fd = FSEED;
    endtask

    task automatic model_step(input logic v, input logic [511:0] d,
                              input logic l, input logic c);
        logic [14:0] e;
        snap_t n;
        e = '0;
        if (c) begin
            m_status = 0; m_err = '0; m_ed = '0; m_pk = '0;
            m_ta = TBASE; m_fc = '0; m_fd = FSEED;
            m_st = (m_st == 0 || (v && l)) ? 0 : 3;
        end else if (v) begin
            if (l) m_pk = m_pk + 1;
            case (m_st)
                0: begin
                    if (d[63:0] != m_ta) e[0] = 1'b1;
                    if (d[95:64] != m_fc) e[1] = 1'b1;
                    if (l) e[3] = 1'b1;
                    if (e == 0) begin m_st = 1; m_bc = 0; end
                end
                1: begin
                    for (int i = 0; i < 16; i++)
                        if (d[32*i +: 32] != m_fd + 32'(i)) e[2] = 1'b1;
                    if (l && m_bc < PB - 1) e[3] = 1'b1;
                    if (!l && m_bc == PB - 1) e[4] = 1'b1;
                    if (e == 0) begin
                        m_fd = m_fd + 32'd16;
                        if (m_bc == PB - 1) begin
                            m_fc = m_fc + 1;
                            m_ta = m_ta + 64'(PB * 64);
                            if (m_ta >= TBASE + TSIZE) m_ta = TBASE;
                            m_st = 0;
                        end else begin
                            m_bc++;
                        end
                    end
                end
                3: if (l) m_st = 0;
                default: ;
            endcase
            if (e != 0) begin
                m_status = 1; m_err = e; m_ed = d; m_st = 2;
            end
        end
        n.st = m_status; n.err = m_err; n.ed = m_ed; n.pk = m_pk;
        n.ta = m_ta; n.fc = m_fc; n.fd = m_fd;
        sb.push_back(n);
    endtask

    always @(posedge clk) begin
        if (resetn && ((tvalid && tready) || clear)) begin
            #1;
            check("sb_level", 512'(sb.size() != 0), 512'(1));
            if (sb.size() != 0) begin
                s = sb.pop_front();
                check("status", 512'(status), 512'(s.st));
                check("error", 512'(error), 512'(s.err));
                check("pkts", 512'(pkts), 512'(s.pk));
                check("taddr", 512'(exp_taddr), 512'(s.ta));
                check("fc", 512'(exp_fc), 512'(s.fc));
                check("fdata", 512'(exp_fdata), 512'(s.fd));
                if (s.st) check("edata", edata, s.ed);
            end
        end
    end

    function automatic logic [511:0] hdr_w(input logic [63:0] ta,
                                           input logic [31:0] fc);
        logic [511:0] w;
        for (int i = 3; i < 16; i++) w[32*i +: 32] = $urandom;
        w[63:0]  = ta;
        w[95:64] = fc;
        return w;
    endfunction

    function automatic logic [511:0] dat_w(input logic [31:0] fd);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[32*i +: 32] = fd + 32'(i);
        return w;
    endfunction

    task automatic beat(input logic [511:0] d, input logic l,
                        input logic c);
        @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = l; clear = c;
        model_step(1'b1, d, l, c);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; clear = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        model_step(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] ta, input logic [31:0] fc,
                            input logic [31:0] fd);
        beat(hdr_w(ta, fc), 1'b0, 1'b0);
        for (int b = 0; b < PB; b++)
            beat(dat_w(fd + 32'(16 * b)), b == PB - 1, 1'b0);
    endtask

    task automatic reset_checks();
        check("rst_tready", 512'(tready), 512'(0));
        check("rst_status", 512'(status), 512'(0));
        check("rst_error", 512'(error), 512'(0));
        check("rst_edata", edata, 512'(0));
        check("rst_pkts", 512'(pkts), 512'(0));
        check("rst_taddr", 512'(exp_taddr), 512'(TBASE));
        check("rst_fc", 512'(exp_fc), 512'(0));
        check("rst_fdata", 512'(exp_fdata), 512'(FSEED));
        check("rst_active", 512'(active), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] bad;
        model_reset();
        #12;
        reset_checks();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("tready_up", 512'(tready), 512'(1));

        send_pkt(64'h000, 32'd0, 32'h00);
        send_pkt(64'h100, 32'd1, 32'h40);
        send_pkt(64'h200, 32'd2, 32'h80);
        check("g3_error", 512'(error), 512'(0));
        check("g3_pkts", 512'(pkts), 512'(3));
        check("g3_fc", 512'(exp_fc), 512'(3));
        check("g3_taddr", 512'(exp_taddr), 512'(64'h300));
        check("g3_fdata", 512'(exp_fdata), 512'(32'hC0));

        send_pkt(64'h300, 32'd3, 32'hC0);
        check("wrap_taddr", 512'(exp_taddr), 512'(0));
        send_pkt(64'h000, 32'd4, 32'h100);
        check("wrap_status", 512'(status), 512'(0));

        do_clear();
        check("clr_pkts", 512'(pkts), 512'(0));
        send_pkt(64'h000, 32'd0, 32'h00);
        bad = dat_w(32'h50);
        bad[5*32 +: 32] = 32'hDEAD;
        beat(hdr_w(64'h100, 32'd1), 1'b0, 1'b0);
        beat(dat_w(32'h40), 1'b0, 1'b0);
        beat(bad, 1'b0, 1'b0);
        check("dead_error", 512'(error), 512'(15'h0004));
        check("dead_status", 512'(status), 512'(1));
        check("dead_edata", edata, bad);
        check("dead_fdata", 512'(exp_fdata), 512'(32'h50));
        beat(dat_w(32'h60), 1'b0, 1'b0);
        beat(dat_w(32'h70), 1'b1, 1'b0);
        send_pkt(64'h200, 32'd2, 32'h80);
        check("err_pkts", 512'(pkts), 512'(3));

        beat(hdr_w(64'h300, 32'd3), 1'b0, 1'b0);
        beat(dat_w(32'hC0), 1'b0, 1'b0);
        do_clear();
        check("mid_status", 512'(status), 512'(0));
        check("mid_pkts", 512'(pkts), 512'(0));
        beat(dat_w(32'h5), 1'b0, 1'b0);
        beat(dat_w(32'h6), 1'b0, 1'b0);
        beat(dat_w(32'h7), 1'b1, 1'b0);
        send_pkt(64'h000, 32'd0, 32'h00);
        check("sync_status", 512'(status), 512'(0));
        check("sync_pkts", 512'(pkts), 512'(2));

        beat(hdr_w(64'h100, 32'd1), 1'b0, 1'b0);
        beat(dat_w(32'h40), 1'b0, 1'b0);
        beat(dat_w(32'h50), 1'b1, 1'b0);
        check("short_error", 512'(error), 512'(15'h0008));
        beat(dat_w(32'h9), 1'b1, 1'b1);
        check("clrlast_pkts", 512'(pkts), 512'(0));
        check("clrlast_status", 512'(status), 512'(0));
        beat(hdr_w(64'h000, 32'd0), 1'b0, 1'b0);
        for (int b = 0; b < PB; b++)
            beat(dat_w(32'(16 * b)), 1'b0, 1'b0);
        check("long_error", 512'(error), 512'(15'h0010));
        beat(dat_w(32'h9), 1'b1, 1'b1);
        beat(hdr_w(64'h040, 32'd7), 1'b0, 1'b0);
        check("hdr_error", 512'(error), 512'(15'h0003));
        do_clear();

        repeat (TOUT + 2) @(negedge clk);
        check("idle_active", 512'(active), 512'(0));
        tvalid = 1'b1; tdata = dat_w(32'h1); tlast = 1'b1;
        model_step(1'b1, tdata, 1'b1, 1'b0);
        for (int k = 1; k <= TOUT + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin tvalid = 1'b0; tlast = 1'b0; end
            check($sformatf("active_%0d", k), 512'(active),
                  512'(k <= TOUT));
        end

        beat(hdr_w(64'h000, 32'd0), 1'b1, 1'b0);
        check("hdrlast_error", 512'(error), 512'(15'h0008));
        beat(dat_w(32'h9), 1'b1, 1'b1);

        beat(hdr_w(64'h000, 32'd0), 1'b0, 1'b0);
        beat(dat_w(32'h00), 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_pkt(64'h000, 32'd0, 32'h00);
        check("prst_status", 512'(status), 512'(0));
        check("prst_pkts", 512'(pkts), 512'(1));
        check("prst_taddr", 512'(exp_taddr), 512'(64'h100));

        repeat (2) @(negedge clk);
        check("sb_drain", 512'(sb.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
